// File: rtl/pipelined_barrel_shifter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : pipelined_barrel_shifter
// Description : Stallable, pipelined barrel shifter/rotator (SLL, SRL, SRA,
//               ROL, ROR) with valid/ready handshakes on input and output.
//               Shift levels are spread over LAT register groups.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_barrel_shifter #(
    parameter int DATA_W = 32,
    parameter int DIST_W = $clog2(DATA_W),
    parameter int LAT    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op,
    input  logic [DIST_W-1:0] dst,
    input  logic [DATA_W-1:0] id,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] od,
    output logic              out_zero,
    output logic              out_illegal
);

    localparam logic [2:0]        c_OP_SLL = 3'b000;
    localparam logic [2:0]        c_OP_SRL = 3'b001;
    localparam logic [2:0]        c_OP_SRA = 3'b010;
    localparam logic [2:0]        c_OP_ROL = 3'b011;
    localparam logic [2:0]        c_OP_ROR = 3'b100;
    localparam logic [DATA_W-1:0] c_ONES   = {DATA_W{1'b1}};

    // One shift level of weight amt. Illegal ops fall to the default and
    // pass the data through untouched, which is what the output requires.
    function automatic logic [DATA_W-1:0] f_level(
        input logic [DATA_W-1:0] data,
        input logic [2:0]        lop,
        input logic              sign,
        input int                amt
    );
        logic [DATA_W-1:0] fill;
        fill = sign ? ~(c_ONES >> amt) : '0;
        case (lop)
            c_OP_SLL: f_level = data << amt;
            c_OP_SRL: f_level = data >> amt;
            c_OP_SRA: f_level = (data >> amt) | fill;
            c_OP_ROL: f_level = (data << amt) | (data >> (DATA_W - amt));
            c_OP_ROR: f_level = (data >> amt) | (data << (DATA_W - amt));
            default:  f_level = data;
        endcase
    endfunction

    // Per-stage registers
    logic [LAT-1:0]    r_valid;
    logic [LAT-1:0]    r_illegal;
    logic [LAT-1:0]    r_sign;
    logic [DATA_W-1:0] r_data [LAT];
    logic [2:0]        r_op   [LAT];
    logic [DIST_W-1:0] r_dst  [LAT];

    // Per-stage inputs (from the ports for stage 0, else from stage k-1)
    logic [LAT-1:0]    w_src_valid;
    logic [LAT-1:0]    w_src_illegal;
    logic [LAT-1:0]    w_src_sign;
    logic [DATA_W-1:0] w_src_data [LAT];
    logic [2:0]        w_src_op   [LAT];
    logic [DIST_W-1:0] w_src_dst  [LAT];
    logic [DATA_W-1:0] w_next_data [LAT];

    // w_ready[k] is ready into stage k; w_ready[LAT] is the downstream ready
    logic [LAT:0]      w_ready;

    // Ready chain: a stage can take a beat when empty or when it empties too
    always_comb begin
        w_ready[LAT] = out_ready;
        for (int k = LAT - 1; k >= 0; k--) begin
            w_ready[k] = !r_valid[k] || w_ready[k+1];
        end
    end

    // Stage sources and the shift levels that belong to each register group
    always_comb begin
        w_src_valid[0]   = in_valid;
        w_src_illegal[0] = (op > c_OP_ROR);
        w_src_sign[0]    = id[DATA_W-1];
        w_src_data[0]    = id;
        w_src_op[0]      = op;
        w_src_dst[0]     = dst;
        for (int k = 1; k < LAT; k++) begin
            w_src_valid[k]   = r_valid[k-1];
            w_src_illegal[k] = r_illegal[k-1];
            w_src_sign[k]    = r_sign[k-1];
            w_src_data[k]    = r_data[k-1];
            w_src_op[k]      = r_op[k-1];
            w_src_dst[k]     = r_dst[k-1];
        end
        for (int k = 0; k < LAT; k++) begin
            w_next_data[k] = w_src_data[k];
            for (int j = 0; j < DIST_W; j++) begin
                if (((j * LAT) / DIST_W) == k && w_src_dst[k][j]) begin
                    w_next_data[k] = f_level(w_next_data[k], w_src_op[k],
                                             w_src_sign[k], 1 << j);
                end
            end
        end
    end

    // Stage registers: load when ready, otherwise hold; reset flushes all
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= '0;
            r_illegal <= '0;
            r_sign    <= '0;
            for (int k = 0; k < LAT; k++) begin
                r_data[k] <= '0;
                r_op[k]   <= '0;
                r_dst[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < LAT; k++) begin
                if (w_ready[k]) begin
                    r_valid[k] <= w_src_valid[k];
                    if (w_src_valid[k]) begin
                        r_data[k]    <= w_next_data[k];
                        r_illegal[k] <= w_src_illegal[k];
                        r_sign[k]    <= w_src_sign[k];
                        r_op[k]      <= w_src_op[k];
                        r_dst[k]     <= w_src_dst[k];
                    end
                end
            end
        end
    end

    assign in_ready    = w_ready[0];
    assign out_valid   = r_valid[LAT-1];
    assign od          = r_data[LAT-1];
    assign out_zero    = r_valid[LAT-1] && (r_data[LAT-1] == '0);
    assign out_illegal = r_valid[LAT-1] && r_illegal[LAT-1];

    // Control fields of the last stage have no consumer past the outputs
    logic w_unused;
    assign w_unused = ^{r_op[LAT-1], r_dst[LAT-1], r_sign[LAT-1]};

endmodule
`default_nettype wire

// File: tb/tb_pipelined_barrel_shifter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_pipelined_barrel_shifter
// Description : Bench for pipelined_barrel_shifter at LAT = 1, 2 and 5 with
//               a shared stimulus and an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_barrel_shifter;

    localparam int c_NDUT  = 3;
    localparam int c_DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [2:0]  op = 3'd0;
    logic [4:0]  dst = 5'd0;
    logic [31:0] id = 32'd0;

    logic [c_NDUT-1:0] in_ready_a;
    logic [c_NDUT-1:0] out_valid_a;
    logic [c_NDUT-1:0] out_zero_a;
    logic [c_NDUT-1:0] out_illegal_a;
    logic [31:0]       od_a [c_NDUT];

    typedef struct packed {
        logic        ill;
        logic [31:0] od;
    } exp_t;

    exp_t        mem [c_NDUT][c_DEPTH];
    int          wp [c_NDUT];
    int          rp [c_NDUT];
    logic        held_v [c_NDUT];
    logic [31:0] held_od [c_NDUT];
    logic        held_z [c_NDUT];
    logic        held_i [c_NDUT];

    int   total = 0;
    int   bad = 0;
    int   out_mode = 0;
    int   pat = 0;
    logic last_acc = 1'b0;

    always #5 clk = ~clk;

    generate
        for (genvar d = 0; d < c_NDUT; d++) begin : g_dut
            localparam int c_LAT = (d == 0) ? 1 : ((d == 1) ? 2 : 5);
            pipelined_barrel_shifter #(.DATA_W(32), .LAT(c_LAT)) u_dut (
                .clk         (clk),
                .rst         (rst),
                .in_valid    (in_valid),
                .in_ready    (in_ready_a[d]),
                .op          (op),
                .dst         (dst),
                .id          (id),
                .out_valid   (out_valid_a[d]),
                .out_ready   (out_ready),
                .od          (od_a[d]),
                .out_zero    (out_zero_a[d]),
                .out_illegal (out_illegal_a[d])
            );
        end
    endgenerate

    function automatic exp_t ref_model(input logic [2:0] o, input logic [4:0] d,
                                       input logic [31:0] v);
        exp_t        e;
        logic [63:0] dbl;
        dbl   = {v, v};
        e.ill = 1'b0;
        case (o)
            3'd0: e.od = v << d;
            3'd1: e.od = v >> d;
            3'd2: e.od = $signed(v) >>> d;
            3'd3: begin dbl = dbl << d; e.od = dbl[63:32]; end
            3'd4: begin dbl = dbl >> d; e.od = dbl[31:0]; end
            default: begin e.od = v; e.ill = 1'b1; end
        endcase
        return e;
    endfunction

    function automatic int outstanding();
        int s;
        s = 0;
        for (int d = 0; d < c_NDUT; d++) s += wp[d] - rp[d];
        return s;
    endfunction

    task automatic cycle();
        exp_t e;
        @(negedge clk);
        if (rst) begin
            for (int d = 0; d < c_NDUT; d++) begin
                wp[d] = 0; rp[d] = 0; held_v[d] = 1'b0;
            end
        end else begin
            for (int d = 0; d < c_NDUT; d++) begin
                if (held_v[d]) begin
                    total++;
                    if (out_valid_a[d] !== 1'b1) begin
                        bad++;
                        $error("FAIL hold_valid: observed=%0h expected=1", out_valid_a[d]);
                    end
                    total++;
                    if (od_a[d] !== held_od[d]) begin
                        bad++;
                        $error("FAIL hold_od: observed=%0h expected=%0h", od_a[d], held_od[d]);
                    end
                    total++;
                    if (out_zero_a[d] !== held_z[d]) begin
                        bad++;
                        $error("FAIL hold_zero: observed=%0h expected=%0h", out_zero_a[d], held_z[d]);
                    end
                    total++;
                    if (out_illegal_a[d] !== held_i[d]) begin
                        bad++;
                        $error("FAIL hold_illegal: observed=%0h expected=%0h", out_illegal_a[d], held_i[d]);
                    end
                end
                if (out_valid_a[d] && out_ready) begin
                    total++;
                    if (wp[d] == rp[d]) begin
                        bad++;
                        $error("FAIL beat_expected: observed=0 expected=1");
                    end
                    if (wp[d] != rp[d]) begin
                        e = mem[d][rp[d] % c_DEPTH];
                        rp[d]++;
                        total++;
                        if (od_a[d] !== e.od) begin
                            bad++;
                            $error("FAIL sb_od: observed=%0h expected=%0h", od_a[d], e.od);
                        end
                        total++;
                        if (out_zero_a[d] !== (e.od == 32'h0)) begin
                            bad++;
                            $error("FAIL sb_zero: observed=%0h expected=%0h", out_zero_a[d], (e.od == 32'h0));
                        end
                        total++;
                        if (out_illegal_a[d] !== e.ill) begin
                            bad++;
                            $error("FAIL sb_illegal: observed=%0h expected=%0h", out_illegal_a[d], e.ill);
                        end
                    end
                    held_v[d] = 1'b0;
                end else begin
                    held_v[d]  = out_valid_a[d];
                    held_od[d] = od_a[d];
                    held_z[d]  = out_zero_a[d];
                    held_i[d]  = out_illegal_a[d];
                end
                if (in_valid && in_ready_a[d]) begin
                    mem[d][wp[d] % c_DEPTH] = ref_model(op, dst, id);
                    wp[d]++;
                end
            end
        end
        last_acc = in_valid && in_ready_a[1];
        @(posedge clk);
        #1;
        pat++;
        case (out_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ((pat % 4) == 0) || ((pat % 4) == 3);
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    endtask

    task automatic push_beat(input logic [2:0] o, input logic [4:0] d,
                             input logic [31:0] v);
        logic ok;
        ok = 1'b0;
        op = o; dst = d; id = v; in_valid = 1'b1;
        for (int t = 0; t < 64 && !ok; t++) begin
            cycle();
            ok = last_acc;
        end
        in_valid = 1'b0;
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $error("FAIL accept_timeout: observed=%0h expected=1", ok);
        end
    endtask

    task automatic drain();
        out_mode = 0;
        for (int t = 0; t < 100 && outstanding() != 0; t++) cycle();
        repeat (3) cycle();
        total++;
        if (outstanding() !== 0) begin
            bad++;
            $error("FAIL drain_empty: observed=%0d expected=0", outstanding());
        end
    endtask

    task automatic directed(input string tag, input logic [2:0] o, input logic [4:0] d,
                            input logic [31:0] v, input logic [31:0] e_od,
                            input logic e_z, input logic e_i);
        push_beat(o, d, v);
        total++;
        if (out_valid_a[1] !== 1'b0) begin
            bad++;
            $error("FAIL %s_early: observed=%0h expected=0", tag, out_valid_a[1]);
        end
        cycle();
        total++;
        if (out_valid_a[1] !== 1'b1) begin
            bad++;
            $error("FAIL %s_valid: observed=%0h expected=1", tag, out_valid_a[1]);
        end
        total++;
        if (od_a[1] !== e_od) begin
            bad++;
            $error("FAIL %s_od: observed=%0h expected=%0h", tag, od_a[1], e_od);
        end
        total++;
        if (out_zero_a[1] !== e_z) begin
            bad++;
            $error("FAIL %s_zero: observed=%0h expected=%0h", tag, out_zero_a[1], e_z);
        end
        total++;
        if (out_illegal_a[1] !== e_i) begin
            bad++;
            $error("FAIL %s_illegal: observed=%0h expected=%0h", tag, out_illegal_a[1], e_i);
        end
        repeat (6) cycle();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        for (int d = 0; d < c_NDUT; d++) begin
            wp[d] = 0; rp[d] = 0; held_v[d] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (out_valid_a !== 3'b000) begin
            bad++;
            $error("FAIL rst_out_valid: observed=%0h expected=0", out_valid_a);
        end
        total++;
        if (od_a[1] !== 32'h0) begin
            bad++;
            $error("FAIL rst_od: observed=%0h expected=0", od_a[1]);
        end
        total++;
        if (out_zero_a !== 3'b000) begin
            bad++;
            $error("FAIL rst_zero: observed=%0h expected=0", out_zero_a);
        end
        total++;
        if (out_illegal_a !== 3'b000) begin
            bad++;
            $error("FAIL rst_illegal: observed=%0h expected=0", out_illegal_a);
        end
        rst = 1'b0;
        cycle();
        total++;
        if (in_ready_a !== 3'b111) begin
            bad++;
            $error("FAIL rst_in_ready: observed=%0h expected=7", in_ready_a);
        end

        directed("sll8",  3'd0, 5'd8,  32'hA5A5A5A5, 32'hA5A5A500, 1'b0, 1'b0);
        directed("srl4",  3'd1, 5'd4,  32'h12345678, 32'h01234567, 1'b0, 1'b0);
        directed("sra4",  3'd2, 5'd4,  32'h80000010, 32'hF8000001, 1'b0, 1'b0);
        directed("srl4b", 3'd1, 5'd4,  32'h80000010, 32'h08000001, 1'b0, 1'b0);
        directed("rol1",  3'd3, 5'd1,  32'h80000001, 32'h00000003, 1'b0, 1'b0);
        directed("ror31", 3'd4, 5'd31, 32'h00000001, 32'h00000002, 1'b0, 1'b0);
        directed("rol0",  3'd3, 5'd0,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0);
        directed("sra0",  3'd2, 5'd0,  32'h80000001, 32'h80000001, 1'b0, 1'b0);
        directed("sll31", 3'd0, 5'd31, 32'h00000001, 32'h80000000, 1'b0, 1'b0);
        directed("sllz",  3'd0, 5'd1,  32'h80000000, 32'h00000000, 1'b1, 1'b0);
        directed("ill7",  3'd7, 5'd5,  32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 1'b1);
        drain();

        out_mode = 3;
        cycle();
        n = 0;
        op = 3'd0; dst = 5'($urandom); id = $urandom; in_valid = 1'b1;
        repeat (6) begin
            cycle();
            if (last_acc) begin
                n++;
                op = 3'($urandom_range(0, 4)); dst = 5'($urandom); id = $urandom;
            end
        end
        total++;
        if (n !== 2) begin
            bad++;
            $error("FAIL fill_count: observed=%0d expected=2", n);
        end
        total++;
        if (in_ready_a[1] !== 1'b0) begin
            bad++;
            $error("FAIL full_in_ready: observed=%0h expected=0", in_ready_a[1]);
        end
        out_ready = 1'b1;
        out_mode = 0;
        cycle();
        total++;
        if (last_acc !== 1'b1) begin
            bad++;
            $error("FAIL full_pass_ready: observed=%0h expected=1", last_acc);
        end
        total++;
        if (out_valid_a[1] !== 1'b1) begin
            bad++;
            $error("FAIL full_no_bubble: observed=%0h expected=1", out_valid_a[1]);
        end
        in_valid = 1'b0;
        drain();

        out_mode = 1;
        pat = 0;
        for (int i = 0; i < 8; i++) push_beat(3'($urandom_range(0, 4)), 5'($urandom), $urandom);
        drain();

        out_mode = 2;
        for (int i = 0; i < 150; i++) begin
            push_beat(3'($urandom_range(0, 7)), 5'($urandom), $urandom);
            if ($urandom_range(0, 7) == 0) cycle();
        end
        drain();

        push_beat(3'd3, 5'd7, 32'h13579BDF);
        push_beat(3'd1, 5'd2, 32'hFFFF0000);
        rst = 1'b1;
        #1;
        total++;
        if (out_valid_a !== 3'b000) begin
            bad++;
            $error("FAIL mid_rst_out_valid: observed=%0h expected=0", out_valid_a);
        end
        total++;
        if (od_a[1] !== 32'h0) begin
            bad++;
            $error("FAIL mid_rst_od: observed=%0h expected=0", od_a[1]);
        end
        cycle();
        rst = 1'b0;
        cycle();
        total++;
        if (out_valid_a !== 3'b000) begin
            bad++;
            $error("FAIL post_rst_no_stale: observed=%0h expected=0", out_valid_a);
        end
        directed("post_rst", 3'd2, 5'd3, 32'h80000F00, 32'hF00001E0, 1'b0, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
Parametrised, pipelined barrel shifter with five shift/rotate modes and a valid/ready handshake on both sides. Input and output are stallable streams, one result per cycle at full throughput. Pipeline depth is configurable so the same block closes timing at wide DATA_W. It is the next-generation shifter for the datapath; the earlier single-mode enable-driven shifter can be replaced by LAT=1, op=SLL/SRL.

Parameters:
DATA_W, 32, data width in bits; must be a power of two, ≥ 2
DIST_W, $clog2(DATA_W), width of shift distance
LAT, 2, number of pipeline register levels, 1..DIST_W; equals the accept-to-output latency

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset
in_valid  in  1  input beat valid
in_ready  out  1  block accepts input this cycle
op  in  3  mode: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR; 101–111 illegal
dst  in  DIST_W  shift/rotate distance, 0..DATA_W-1
id  in  DATA_W  input data
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts output
od  out  DATA_W  result
out_zero  out  1  od == 0, qualified by out_valid
out_illegal  out  1  beat carried an illegal op, qualified by out_valid

Behaviour:
- Interface timing: one clock; reset is asynchronous and active-high.
- Reset, asynchronous on rst high: all stage valid bits 0, out_valid 0, od 0, out_zero 0, out_illegal 0. in_ready reads 1 once rst deasserts.
- Reset mid-operation: every in-flight beat is discarded. No output beat is produced for it.
- Input handshake: a beat is accepted when in_valid && in_ready. Output handshake: a beat is consumed when out_valid && out_ready.
- Shift levels: DIST_W levels, level j shifts by 2^j when dst[j] = 1. Level j is placed in register group g = floor(j*LAT/DIST_W). Each group ends with a register level, so the last group's register drives the outputs.
- Per stage, register valid_k plus the partially shifted data. Also carry op, the remaining dst bits, sign = id[DATA_W-1] captured at accept, and the illegal flag.
- Ready chain (purely combinational):
  - ready_k = !valid_k || ready_(k+1)
  - ready_LAT = out_ready
  - in_ready = ready_0
  - A stage loads when its upstream is valid and ready_k is 1. Otherwise it holds. A bubble anywhere lets upstream advance.
- Latency and throughput: with out_ready held 1, a beat accepted at edge N appears with out_valid=1 after edge N+LAT-1, i.e. LAT cycles. Throughput is one beat per cycle. No beat is dropped or duplicated under any out_ready pattern.
- Stall: while out_valid && !out_ready, od, out_zero and out_illegal hold stable. The pipeline fills up to LAT beats, then in_ready = 0.
- Mode arithmetic:
  - SLL: zero fill from the LSB.
  - SRL: zero fill from the MSB.
  - SRA: fill with the captured sign at every level.
  - ROL / ROR: bits wrap modulo DATA_W.
  - dst = 0: od = id for every legal op.
- Illegal op (101–111): od = id unshifted, out_illegal = 1. Ordering and handshake are unaffected.
- out_zero is computed combinationally from the output register; no extra latency.
- Simultaneous accept and consume on a full pipeline is allowed: in_ready = 1 when out_ready = 1 because the ready chain propagates. The pipeline stays full with no bubble.

Test Plan:
- Reset then single beats, LAT=2, out_ready=1:
  - SLL id=A5A5A5A5 dst=8 -> od=A5A5A500, two cycles after accept
  - SRL id=12345678 dst=4 -> od=01234567
- SRA id=80000010 dst=4 -> od=F8000001; same id with SRL -> 08000001.
- Rotates:
  - ROL id=80000001 dst=1 -> od=00000003
  - ROR id=00000001 dst=31 -> od=00000002
  - ROL id=DEADBEEF dst=0 -> od=DEADBEEF
  - SLL id=00000001 dst=31 -> 80000000 then SLL 80000000 dst=1 -> od=0, out_zero=1
- Illegal op=111 id=CAFEF00D dst=5 -> od=CAFEF00D, out_illegal=1.
- Backpressure:
  - Stream 8 beats back-to-back and toggle out_ready 1,0,0,1,…
  - in_ready drops to 0 after LAT beats are held.
  - Output order and values must match a reference model; od holds while stalled; no loss or duplication.
- Assert rst for one cycle with 2 beats in flight -> out_valid=0 immediately. No stale beat appears after release; the next beat's result is correct at LAT=1, 2 and DIST_W.
